alu_operand_stage: RTL and testbench
====================================

# alu_operand_stage

Registered operand-preparation stage directly upstream of `alu`. It accepts a decoded ARMv4 data-processing operation and computes the shifter operand (operand 2) and the shifter carry-out. Immediate rotates, immediate shifts and register-specified shifts are all handled. The stage then presents `A`, `B`, `ALU_Sel` and the carry to the ALU through a one-entry valid/ready output buffer. Register-specified shifts take one extra cycle, matching ARMv4 execute timing.

## Interface
- No parameters; datapath fixed at 32 bits.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: upstream operation valid.
- `in_ready` out 1: stage can accept.
- `imm_sel` in 1: 1 = rotated immediate operand; 0 = shifted register.
- `imm8` in 8: immediate value.
- `rot4` in 4: rotate field; rotation amount = 2*rot4.
- `rm_val` in 32: Rm value.
- `shift_type` in 2: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
- `shift_by_reg` in 1: 1 = amount from `rs_val[7:0]`; 0 = from `shift_imm`.
- `shift_imm` in 5: immediate shift amount.
- `rs_val` in 32: Rs value; only bits [7:0] are used.
- `rn_val` in 32: Rn value; passed through to `A`.
- `alu_sel_in` in 4: ALU opcode; passed through to `ALU_Sel`.
- `c_in` in 1: current CPSR C flag.
- `out_valid` out 1: `A`/`B`/`ALU_Sel`/`shifter_carry` are valid.
- `out_ready` in 1: ALU side consumes.
- `A` out 32: registered Rn.
- `B` out 32: registered shifter operand.
- `ALU_Sel` out 4: registered opcode.
- `shifter_carry` out 1: registered shifter carry-out.

## Operation
- FSM states:
  - IDLE: buffer empty.
  - RSHIFT: register-shift operands latched; result computed next edge.
  - HOLD: output buffer full.
- Transfer rules:
  - Accept when `in_valid & in_ready`.
  - Output transfer when `out_valid & out_ready`.
- `in_ready` = (state==IDLE) | (state==HOLD & `out_ready`).
  - Forced 0 while `rst`=1.
  - 0 in RSHIFT.
- Accept of immediate or imm-shift op → HOLD with result.
- Accept of register-shift op → RSHIFT, with `rm_val`, `rs_val[7:0]`, `shift_type`, `c_in`, `rn_val`, `alu_sel_in` latched. The next edge → HOLD with result.
- HOLD with `out_ready`=1 and no accept → IDLE.
  - With a same-cycle accept → HOLD or RSHIFT according to the new op.
- HOLD with `out_ready`=0: all outputs hold stable.
- `c_in` is sampled at acceptance only.
- Immediate operand:
  - `B` = ror(zero-extended `imm8`, 2*`rot4`).
  - carry = `c_in` if `rot4`==0, else `B[31]`.
- Immediate shift, n=`shift_imm`:
  - LSL #0: `B`=Rm, c=`c_in`.
  - LSL n: `B`=Rm<<n, c=Rm[32-n].
  - LSR #0 encodes LSR #32: `B`=0, c=Rm[31]. LSR n: `B`=Rm>>n, c=Rm[n-1].
  - ASR #0 encodes ASR #32: `B`={32{Rm[31]}}, c=Rm[31]. ASR n: arithmetic shift, c=Rm[n-1].
  - ROR #0 encodes RRX: `B`={`c_in`,Rm[31:1]}, c=Rm[0]. ROR n: `B`=ror(Rm,n), c=Rm[n-1].
- Register shift, s=Rs[7:0]:
  - s==0 (any type): `B`=Rm, c=`c_in`.
  - LSL:
    - s<32: `B`=Rm<<s, c=Rm[32-s].
    - s==32: `B`=0, c=Rm[0].
    - s>32: `B`=0, c=0.
  - LSR:
    - s<32: `B`=Rm>>s, c=Rm[s-1].
    - s==32: `B`=0, c=Rm[31].
    - s>32: `B`=0, c=0.
  - ASR:
    - s<32: arithmetic shift, c=Rm[s-1].
    - s≥32: `B`={32{Rm[31]}}, c=Rm[31].
  - ROR, s nonzero:
    - s[4:0]==0: `B`=Rm, c=Rm[31].
    - Otherwise: `B`=ror(Rm,s[4:0]), c=Rm[s[4:0]-1].

## Timing
- Reset values (registered outputs, one edge after `rst`=1):
  - state IDLE.
  - `out_valid`=0.
  - `A`=0, `B`=0, `ALU_Sel`=0, `shifter_carry`=0.
- Reset in any state, including RSHIFT or HOLD, discards the in-flight op; no output transfer occurs.
- Latency, accept edge to `out_valid`=1:
  - Immediate and imm-shift ops: 1 cycle.
  - Register-shift ops: 2 cycles.
- Throughput:
  - 1 op/cycle for non-register shifts while `out_ready`=1.
  - 1 op per 2 cycles for register shifts.
- `out_valid` never drops without a transfer or reset.
- Output fields do not change while `out_valid`=1 and `out_ready`=0.
- Input fields are don't-care unless `in_valid & in_ready`.

## Test plan
- Immediate rotate:
  - `imm8`=0xFF, `rot4`=4, `c_in`=0 → `B`=0xFF000000, carry=1, `out_valid` one cycle after accept.
  - `rot4`=0, `c_in`=1 → `B`=0x000000FF, carry=1.
- Immediate-shift special encodings:
  - LSR #0 with Rm=0x80000001 → `B`=0, carry=1.
  - ASR #0 with Rm=0x80000000 → `B`=0xFFFFFFFF, carry=1.
  - ROR #0 (RRX) with Rm=0x00000003, `c_in`=1 → `B`=0x80000001, carry=1.
- Register LSL boundaries, Rm=0xFFFFFFFF:
  - Rs=32 → `B`=0, carry=1.
  - Rs=33 → `B`=0, carry=0.
  - Rs=0x100 (low byte 0), `c_in`=0 → `B`=0xFFFFFFFF, carry=0.
  - Each case: `in_ready`=0 in the cycle after accept and `out_valid` 2 cycles after accept.
- Register ROR:
  - Rs=0x20, Rm=0x80000000 → `B`=0x80000000, carry=1.
  - Rs=4, Rm=0x0000000F → `B`=0xF0000000, carry=1.
- Backpressure:
  - Hold `out_ready`=0 for 5 cycles with `in_valid`=1 → outputs stable, `in_ready`=0.
  - Raise `out_ready` → transfer and a same-cycle accept of the next immediate op; its result appears next cycle with no bubble.
- Reset mid-operation:
  - Assert `rst` during RSHIFT → next cycle `out_valid`=0, all outputs 0, no transfer.
  - Deassert → `in_ready`=1.

Source files
------------

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: registered ARMv4 shifter-operand preparation feeding the ALU.
// Computes operand 2 (B) and the shifter carry-out for rotated immediates,
// immediate shifts and register-specified shifts, then holds A/B/ALU_Sel/carry
// in a one-entry valid/ready buffer. Register shifts spend one extra cycle in
// RSHIFT so the shift is evaluated from latched operands.
module alu_operand_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        imm_sel,
    input  logic [7:0]  imm8,
    input  logic [3:0]  rot4,
    input  logic [31:0] rm_val,
    input  logic [1:0]  shift_type,
    input  logic        shift_by_reg,
    input  logic [4:0]  shift_imm,
    input  logic [31:0] rs_val,
    input  logic [31:0] rn_val,
    input  logic [3:0]  alu_sel_in,
    input  logic        c_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] A,
    output logic [31:0] B,
    output logic [3:0]  ALU_Sel,
    output logic        shifter_carry
);

    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RSHIFT = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t state;

    // Operands captured for a register-specified shift while in RSHIFT
    logic [31:0] rm_q;
    logic [7:0]  rs_q;
    logic [1:0]  type_q;
    logic        cin_q;
    logic [31:0] rn_q;
    logic [3:0]  sel_q;

    // Results of the single-cycle path (rotated immediate or immediate shift)
    logic [31:0] direct_b;
    logic        direct_c;

    // Results of the register-shift path, evaluated from the latched operands
    logic [31:0] reg_b;
    logic        reg_c;

    logic accept;
    logic is_reg_shift;

    // Only the low byte of Rs carries a shift amount; the rest is ignored
    logic unused_rs_high;
    assign unused_rs_high = ^rs_val[31:8];

    // Rotate right by 0..31; a rotate of zero leaves the value untouched
    function automatic logic [31:0] ror32(input logic [31:0] v, input logic [4:0] n);
        logic [5:0] back;
        back = 6'd32 - {1'b0, n};
        return (v >> n) | (v << back);
    endfunction

    // Arithmetic shift right by 0..31
    function automatic logic [31:0] asr32(input logic [31:0] v, input logic [4:0] n);
        return $unsigned($signed(v) >>> n);
    endfunction

    // Immediate-amount shift; returns {carry, result}. Amount 0 selects the
    // special encodings LSR #32, ASR #32 and RRX for the non-LSL types.
    function automatic logic [32:0] imm_shift(input logic [31:0] rm,
                                              input logic [1:0]  st,
                                              input logic [4:0]  n,
                                              input logic        cin);
        logic [32:0] res;
        res = {cin, rm};
        case (st)
            SH_LSL: begin
                if (n == 5'd0) res = {cin, rm};
                else           res = {rm[5'd0 - n], rm << n};
            end
            SH_LSR: begin
                if (n == 5'd0) res = {rm[31], 32'd0};
                else           res = {rm[n - 5'd1], rm >> n};
            end
            SH_ASR: begin
                if (n == 5'd0) res = {rm[31], {32{rm[31]}}};
                else           res = {rm[n - 5'd1], asr32(rm, n)};
            end
            SH_ROR: begin
                if (n == 5'd0) res = {rm[0], cin, rm[31:1]};
                else           res = {rm[n - 5'd1], ror32(rm, n)};
            end
            default: res = {cin, rm};
        endcase
        return res;
    endfunction

    // Register-amount shift using the full 8-bit amount; returns {carry, result}.
    // Amounts of 32 and above saturate per shift type, and ROR wraps modulo 32.
    function automatic logic [32:0] reg_shift(input logic [31:0] rm,
                                              input logic [1:0]  st,
                                              input logic [7:0]  s,
                                              input logic        cin);
        logic [32:0] res;
        logic [4:0]  lo;
        logic        big;
        logic        is32;
        lo   = s[4:0];
        big  = |s[7:5];
        is32 = (s == 8'd32);
        res  = {cin, rm};
        if (s != 8'd0) begin
            case (st)
                SH_LSL: begin
                    if (!big)      res = {rm[5'd0 - lo], rm << lo};
                    else if (is32) res = {rm[0], 32'd0};
                    else           res = 33'd0;
                end
                SH_LSR: begin
                    if (!big)      res = {rm[lo - 5'd1], rm >> lo};
                    else if (is32) res = {rm[31], 32'd0};
                    else           res = 33'd0;
                end
                SH_ASR: begin
                    if (!big)      res = {rm[lo - 5'd1], asr32(rm, lo)};
                    else           res = {rm[31], {32{rm[31]}}};
                end
                SH_ROR: begin
                    if (lo == 5'd0) res = {rm[31], rm};
                    else            res = {rm[lo - 5'd1], ror32(rm, lo)};
                end
                default: res = {cin, rm};
            endcase
        end
        return res;
    endfunction

    // The buffer accepts when empty, or when full and draining this cycle
    assign in_ready     = ~rst & ((state == IDLE) | ((state == HOLD) & out_ready));
    assign accept       = in_valid & in_ready;
    assign is_reg_shift = ~imm_sel & shift_by_reg;

    // Single-cycle operand 2 and carry straight from the incoming operation
    always_comb begin
        logic [31:0] rot_b;
        logic [32:0] sh_res;
        rot_b    = ror32({24'd0, imm8}, {rot4, 1'b0});
        sh_res   = imm_shift(rm_val, shift_type, shift_imm, c_in);
        direct_b = sh_res[31:0];
        direct_c = sh_res[32];
        if (imm_sel) begin
            direct_b = rot_b;
            direct_c = (rot4 == 4'd0) ? c_in : rot_b[31];
        end
    end

    // Register-specified shift evaluated from the operands latched at accept
    always_comb begin
        logic [32:0] rs_res;
        rs_res = reg_shift(rm_q, type_q, rs_q, cin_q);
        reg_b  = rs_res[31:0];
        reg_c  = rs_res[32];
    end

    // Control FSM plus the registered output buffer and register-shift latches
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            out_valid     <= 1'b0;
            A             <= 32'd0;
            B             <= 32'd0;
            ALU_Sel       <= 4'd0;
            shifter_carry <= 1'b0;
            rm_q          <= 32'd0;
            rs_q          <= 8'd0;
            type_q        <= 2'd0;
            cin_q         <= 1'b0;
            rn_q          <= 32'd0;
            sel_q         <= 4'd0;
        end else if (accept) begin
            if (is_reg_shift) begin
                state     <= RSHIFT;
                out_valid <= 1'b0;
                rm_q      <= rm_val;
                rs_q      <= rs_val[7:0];
                type_q    <= shift_type;
                cin_q     <= c_in;
                rn_q      <= rn_val;
                sel_q     <= alu_sel_in;
            end else begin
                state         <= HOLD;
                out_valid     <= 1'b1;
                A             <= rn_val;
                B             <= direct_b;
                ALU_Sel       <= alu_sel_in;
                shifter_carry <= direct_c;
            end
        end else begin
            case (state)
                RSHIFT: begin
                    state         <= HOLD;
                    out_valid     <= 1'b1;
                    A             <= rn_q;
                    B             <= reg_b;
                    ALU_Sel       <= sel_q;
                    shifter_carry <= reg_c;
                end
                HOLD: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                IDLE: begin
                    out_valid <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
// tb_alu_operand_stage: directed stimulus for alu_operand_stage with an
// operation-level reference model and a per-cycle output scoreboard.
module tb_alu_operand_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        imm_sel;
    logic [7:0]  imm8;
    logic [3:0]  rot4;
    logic [31:0] rm_val;
    logic [1:0]  shift_type;
    logic        shift_by_reg;
    logic [4:0]  shift_imm;
    logic [31:0] rs_val;
    logic [31:0] rn_val;
    logic [3:0]  alu_sel_in;
    logic        c_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  ALU_Sel;
    logic        shifter_carry;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic        imm_sel;
        logic [7:0]  imm8;
        logic [3:0]  rot4;
        logic [31:0] rm;
        logic [1:0]  st;
        logic        by_reg;
        logic [4:0]  shimm;
        logic [31:0] rs;
        logic [31:0] rn;
        logic [3:0]  sel;
        logic        cin;
    } op_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  sel;
        logic        c;
        int          due;
    } exp_t;

    exp_t q[$];
    bit   prev_rst = 1'b0;

    alu_operand_stage dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .imm_sel      (imm_sel),
        .imm8         (imm8),
        .rot4         (rot4),
        .rm_val       (rm_val),
        .shift_type   (shift_type),
        .shift_by_reg (shift_by_reg),
        .shift_imm    (shift_imm),
        .rs_val       (rs_val),
        .rn_val       (rn_val),
        .alu_sel_in   (alu_sel_in),
        .c_in         (c_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .A            (A),
        .B            (B),
        .ALU_Sel      (ALU_Sel),
        .shifter_carry(shifter_carry)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Count rising edges so the scoreboard knows when a result is due
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: shifts are applied one bit position at a time, with the
    // carry being the last bit shifted out; returns {carry, operand2}.
    function automatic logic [32:0] model(input op_t op);
        logic [31:0] v;
        logic        c;
        int          amt;
        v = op.rm;
        c = op.cin;
        if (op.imm_sel) begin
            v = {24'd0, op.imm8};
            for (int i = 0; i < 2 * int'(op.rot4); i++) v = {v[0], v[31:1]};
            c = (op.rot4 == 4'd0) ? op.cin : v[31];
            return {c, v};
        end
        if (op.by_reg) begin
            amt = int'(op.rs[7:0]);
        end else begin
            amt = int'(op.shimm);
            if (amt == 0 && op.st == 2'b11) return {op.rm[0], op.cin, op.rm[31:1]};
            if (amt == 0 && op.st != 2'b00) amt = 32;
        end
        for (int i = 0; i < amt; i++) begin
            case (op.st)
                2'b00:   begin c = v[31]; v = v << 1; end
                2'b01:   begin c = v[0];  v = v >> 1; end
                2'b10:   begin c = v[0];  v = {v[31], v[31:1]}; end
                default: begin c = v[0];  v = {v[0], v[31:1]}; end
            endcase
        end
        return {c, v};
    endfunction

    function automatic op_t mk_imm(input logic [7:0] i8, input logic [3:0] r, input logic cin,
                                   input logic [31:0] rn, input logic [3:0] sel);
        op_t o;
        o = '{imm_sel: 1'b1, imm8: i8, rot4: r, rm: 32'hDEADBEEF, st: 2'b11, by_reg: 1'b1,
              shimm: 5'd7, rs: 32'h00000005, rn: rn, sel: sel, cin: cin};
        return o;
    endfunction

    function automatic op_t mk_ish(input logic [31:0] rm, input logic [1:0] st, input logic [4:0] n,
                                   input logic cin);
        op_t o;
        o = '{imm_sel: 1'b0, imm8: 8'hA5, rot4: 4'd3, rm: rm, st: st, by_reg: 1'b0,
              shimm: n, rs: 32'h00000009, rn: rm ^ 32'h0F0F0F0F, sel: {st, n[1:0]}, cin: cin};
        return o;
    endfunction

    function automatic op_t mk_rsh(input logic [31:0] rm, input logic [1:0] st, input logic [31:0] rs,
                                   input logic cin);
        op_t o;
        o = '{imm_sel: 1'b0, imm8: 8'h3C, rot4: 4'd9, rm: rm, st: st, by_reg: 1'b1,
              shimm: 5'd17, rs: rs, rn: rs + 32'h1000, sel: {2'b10, st}, cin: cin};
        return o;
    endfunction

    task automatic drive(input op_t op);
        imm_sel      = op.imm_sel;
        imm8         = op.imm8;
        rot4         = op.rot4;
        rm_val       = op.rm;
        shift_type   = op.st;
        shift_by_reg = op.by_reg;
        shift_imm    = op.shimm;
        rs_val       = op.rs;
        rn_val       = op.rn;
        alu_sel_in   = op.sel;
        c_in         = op.cin;
        in_valid     = 1'b1;
    endtask

    // Present one op until it is accepted, then drop in_valid just after the accept edge
    task automatic applyStimulus(input op_t op);
        int waited;
        waited = 0;
        drive(op);
        @(negedge clk);
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            errors++;
            checks++;
            $display("[TB] FAIL accept_timeout: got in_ready=%b expected 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic checkOutput(input string name, input op_t op, input logic [31:0] exp_b,
                               input logic exp_c);
        chk({name, ".out_valid"}, out_valid, 1);
        chk({name, ".B"}, B, exp_b);
        chk({name, ".carry"}, shifter_carry, exp_c);
        chk({name, ".A"}, A, op.rn);
        chk({name, ".ALU_Sel"}, ALU_Sel, op.sel);
    endtask

    // Register-shift op: RSHIFT for one cycle, then the result
    task automatic checkRegOp(input string name, input op_t op, input logic [31:0] exp_b,
                              input logic exp_c);
        applyStimulus(op);
        chk({name, ".in_ready_rshift"}, in_ready, 0);
        chk({name, ".out_valid_rshift"}, out_valid, 0);
        @(posedge clk);
        #1;
        checkOutput(name, op, exp_b, exp_c);
    endtask

    // Scoreboard: every cycle, compare handshake and output buffer with the model
    always @(negedge clk) begin
        logic  exp_valid;
        logic  exp_ready;
        exp_t  e;
        logic [32:0] r;
        op_t   cur;
        exp_valid = (q.size() > 0) && (q[0].due <= cyc);
        exp_ready = !rst && ((q.size() == 0) || (exp_valid && out_ready));
        if (prev_rst) begin
            chk("sb.reset_A", A, 32'd0);
            chk("sb.reset_B", B, 32'd0);
            chk("sb.reset_sel", ALU_Sel, 4'd0);
            chk("sb.reset_carry", shifter_carry, 0);
        end
        chk("sb.out_valid", out_valid, exp_valid);
        chk("sb.in_ready", in_ready, exp_ready);
        if (exp_valid && out_valid) begin
            chk("sb.A", A, q[0].a);
            chk("sb.B", B, q[0].b);
            chk("sb.ALU_Sel", ALU_Sel, q[0].sel);
            chk("sb.carry", shifter_carry, q[0].c);
        end
        if (rst) begin
            q.delete();
        end else begin
            if (exp_valid && out_ready) void'(q.pop_front());
            if (in_valid && in_ready) begin
                cur = '{imm_sel: imm_sel, imm8: imm8, rot4: rot4, rm: rm_val, st: shift_type,
                        by_reg: shift_by_reg, shimm: shift_imm, rs: rs_val, rn: rn_val,
                        sel: alu_sel_in, cin: c_in};
                r = model(cur);
                e.a   = rn_val;
                e.b   = r[31:0];
                e.c   = r[32];
                e.sel = alu_sel_in;
                e.due = cyc + ((!imm_sel && shift_by_reg) ? 2 : 1);
                q.push_back(e);
            end
        end
        prev_rst = rst;
    end

    // Hard stop if the stimulus ever stalls
    initial begin
        #200000;
        errors++;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        op_t op;
        op_t mix[$];
        rst = 1'b1;
        out_ready = 1'b1;
        drive(mk_imm(8'h00, 4'd0, 1'b0, 32'd0, 4'd0));
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.out_valid", out_valid, 0);
        chk("reset.A", A, 32'd0);
        chk("reset.B", B, 32'd0);
        chk("reset.ALU_Sel", ALU_Sel, 4'd0);
        chk("reset.carry", shifter_carry, 0);
        rst = 1'b0;
        #1;
        chk("reset.in_ready", in_ready, 1);

        $display("[TB] immediate rotate");
        op = mk_imm(8'hFF, 4'd4, 1'b0, 32'h12345678, 4'hA);
        applyStimulus(op);
        checkOutput("imm_rot8", op, 32'hFF000000, 1'b1);
        op = mk_imm(8'hFF, 4'd0, 1'b1, 32'h00000042, 4'h3);
        applyStimulus(op);
        checkOutput("imm_rot0", op, 32'h000000FF, 1'b1);

        $display("[TB] immediate-shift special encodings");
        op = mk_ish(32'h80000001, 2'b01, 5'd0, 1'b0);
        applyStimulus(op);
        checkOutput("lsr32", op, 32'h00000000, 1'b1);
        op = mk_ish(32'h80000000, 2'b10, 5'd0, 1'b0);
        applyStimulus(op);
        checkOutput("asr32", op, 32'hFFFFFFFF, 1'b1);
        op = mk_ish(32'h00000003, 2'b11, 5'd0, 1'b1);
        applyStimulus(op);
        checkOutput("rrx", op, 32'h80000001, 1'b1);

        $display("[TB] register LSL boundaries");
        checkRegOp("lsl_rs32", mk_rsh(32'hFFFFFFFF, 2'b00, 32'd32, 1'b0), 32'h00000000, 1'b1);
        checkRegOp("lsl_rs33", mk_rsh(32'hFFFFFFFF, 2'b00, 32'd33, 1'b1), 32'h00000000, 1'b0);
        checkRegOp("lsl_rs256", mk_rsh(32'hFFFFFFFF, 2'b00, 32'h100, 1'b0), 32'hFFFFFFFF, 1'b0);

        $display("[TB] register ROR");
        checkRegOp("ror_rs32", mk_rsh(32'h80000000, 2'b11, 32'h20, 1'b0), 32'h80000000, 1'b1);
        checkRegOp("ror_rs4", mk_rsh(32'h0000000F, 2'b11, 32'd4, 1'b0), 32'hF0000000, 1'b1);

        $display("[TB] mixed back-to-back operations");
        mix.push_back(mk_ish(32'h40000001, 2'b00, 5'd1, 1'b0));
        mix.push_back(mk_ish(32'h00000001, 2'b00, 5'd31, 1'b1));
        mix.push_back(mk_ish(32'h80000003, 2'b01, 5'd1, 1'b0));
        mix.push_back(mk_ish(32'hF0000000, 2'b10, 5'd4, 1'b0));
        mix.push_back(mk_ish(32'h12345678, 2'b11, 5'd8, 1'b1));
        mix.push_back(mk_imm(8'h81, 4'd15, 1'b0, 32'h0000BEEF, 4'h7));
        mix.push_back(mk_rsh(32'h80000001, 2'b01, 32'd32, 1'b0));
        mix.push_back(mk_rsh(32'h80000001, 2'b01, 32'd33, 1'b1));
        mix.push_back(mk_rsh(32'h80000002, 2'b01, 32'd1, 1'b1));
        mix.push_back(mk_rsh(32'h80000000, 2'b10, 32'd40, 1'b0));
        mix.push_back(mk_rsh(32'h7FFFFFFF, 2'b10, 32'd31, 1'b0));
        mix.push_back(mk_rsh(32'h00000001, 2'b11, 32'd33, 1'b0));
        mix.push_back(mk_rsh(32'h0000F00F, 2'b11, 32'h200, 1'b1));
        mix.push_back(mk_rsh(32'h00000003, 2'b00, 32'd31, 1'b0));
        mix.push_back(mk_rsh(32'hFFFFFFFF, 2'b01, 32'hFF, 1'b1));
        mix.push_back(mk_ish(32'h0000FFFF, 2'b01, 5'd16, 1'b0));
        foreach (mix[i]) applyStimulus(mix[i]);
        repeat (3) @(posedge clk);
        #1;

        $display("[TB] backpressure");
        out_ready = 1'b0;
        op = mk_imm(8'h03, 4'd1, 1'b0, 32'hAAAA5555, 4'h9);
        applyStimulus(op);
        checkOutput("bp_first", op, 32'hC0000000, 1'b1);
        drive(mk_imm(8'h3F, 4'd0, 1'b0, 32'h0BADF00D, 4'h2));
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk("bp.in_ready_held", in_ready, 0);
            chk("bp.B_stable", B, 32'hC0000000);
            chk("bp.out_valid_held", out_valid, 1);
        end
        out_ready = 1'b1;
        #1;
        chk("bp.in_ready_release", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkOutput("bp_next", mk_imm(8'h3F, 4'd0, 1'b0, 32'h0BADF00D, 4'h2), 32'h0000003F, 1'b0);

        $display("[TB] reset during RSHIFT");
        applyStimulus(mk_rsh(32'h00000005, 2'b00, 32'd1, 1'b0));
        rst = 1'b1;
        #1;
        chk("rst.in_ready_forced", in_ready, 0);
        @(posedge clk);
        #1;
        chk("rst.out_valid", out_valid, 0);
        chk("rst.A", A, 32'd0);
        chk("rst.B", B, 32'd0);
        chk("rst.ALU_Sel", ALU_Sel, 4'd0);
        chk("rst.carry", shifter_carry, 0);
        rst = 1'b0;
        #1;
        chk("rst.in_ready_after", in_ready, 1);
        op = mk_imm(8'h55, 4'd0, 1'b0, 32'h00001234, 4'h5);
        applyStimulus(op);
        checkOutput("post_reset", op, 32'h00000055, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
